hdlc_rx_frontend: RTL

Parametrised synthesizable HDLC receive front-end that replaces the hard-wired flag and abort detection in the Rx path. It takes one serial bit per Clk and performs flag, abort and idle detection, zero-bit de-stuffing, framing and DATA_W-bit word assembly (LSB first). It also provides length checks and saturating event counters for the status/control register. It sits between the line-side Rx input and the Rx buffer/register interface.

---
 rtl/hdlc_rx_pkg.sv | 14 +
 rtl/hdlc_sat_counter.sv | 32 +++
 rtl/hdlc_rx_frontend.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hdlc_rx_pkg.sv
// hdlc_rx_pkg: shared types and constants for the HDLC receive front-end.
// Holds the FSM state encoding, the flag octet and the bit-stuffing run length.
package hdlc_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    FRAME
  } state_e;

  localparam logic [7:0] FLAG_PATTERN = 8'h7E;
  localparam int         STUFF_ONES   = 5;

endpackage

// File: rtl/hdlc_sat_counter.sv
// hdlc_sat_counter: saturating event counter with synchronous clear.
// Ports: clk_i, rst_i (async, active-high), inc_i, clr_i (wins over inc_i),
//        cnt_o (holds at all-ones).
module hdlc_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hdlc_rx_frontend.sv
// hdlc_rx_frontend: HDLC Rx flag/abort/idle detection, de-stuffing, framing,
// LSB-first word assembly, length checks and saturating statistics.
// Ports: Clk, Rst (async, active-high), Rx (line bit), Cnt_Clear;
//   pulses Rx_FlagDetect/AbortDetect/AbortSignal/WrBuff/EoF/FrameError;
//   levels Rx_IdleDetect/ValidFrame/Overflow; Rx_Data; three counters.
module hdlc_rx_frontend
  import hdlc_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ONES_ABORT = 7,
  parameter int ONES_IDLE  = 15,
  parameter int MIN_WORDS  = 2,
  parameter int MAX_WORDS  = 128,
  parameter int CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Rx,
  input  logic              Cnt_Clear,
  output logic              Rx_FlagDetect,
  output logic              Rx_AbortDetect,
  output logic              Rx_AbortSignal,
  output logic              Rx_IdleDetect,
  output logic              Rx_ValidFrame,
  output logic [DATA_W-1:0] Rx_Data,
  output logic              Rx_WrBuff,
  output logic              Rx_EoF,
  output logic              Rx_FrameError,
  output logic              Rx_Overflow,
  output logic [CNT_W-1:0]  Rx_FlagCnt,
  output logic [CNT_W-1:0]  Rx_AbortCnt,
  output logic [CNT_W-1:0]  Rx_ErrCnt
);

  localparam int OW = $clog2(ONES_IDLE + 1);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int WW = $clog2(MAX_WORDS + 2);

  localparam logic [OW-1:0] O_STUFF = OW'(STUFF_ONES);
  localparam logic [OW-1:0] O_ABORT = OW'(ONES_ABORT);
  localparam logic [OW-1:0] O_IDLE  = OW'(ONES_IDLE);
  localparam logic [BW-1:0] B_LAST  = BW'(DATA_W - 1);
  localparam logic [WW-1:0] W_MIN   = WW'(MIN_WORDS);
  localparam logic [WW-1:0] W_MAX   = WW'(MAX_WORDS);
  localparam logic [WW-1:0] W_OVF   = WW'(MAX_WORDS + 1);

  state_e            state_q, state_d;
  logic [7:0]        sr_q, sr_d;
  logic [7:0]        mask_q, mask_d;
  logic [OW-1:0]     ones_q, ones_d;
  logic [BW-1:0]     bit_q, bit_d, bcur;
  logic [WW-1:0]     wcnt_q, wcnt_d, wcur;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic flag_q, flag_d, adet_q, adet_d, asig_q, asig_d;
  logic idle_q, idle_d, eof_q, eof_d, err_q, err_d;
  logic wr_q, wr_d, ovf_q, ovf_d;

  logic flag_hit, abort_hit, idle_hit, stuffed;

  assign flag_hit  = (sr_q == FLAG_PATTERN);
  assign abort_hit = (ones_q == O_ABORT);
  assign idle_hit  = (ones_q == O_IDLE);
  assign stuffed   = !Rx && (ones_q == O_STUFF);

  // The first data bit seen in SYNC starts a fresh frame.
  assign bcur = (state_q == SYNC) ? '0 : bit_q;
  assign wcur = (state_q == SYNC) ? '0 : wcnt_q;

  always_comb begin
    sr_d    = {sr_q[6:0], Rx};
    mask_d  = {mask_q[6:0], ~stuffed};
    ones_d  = '0;
    state_d = state_q;
    bit_d   = bit_q;
    wcnt_d  = wcnt_q;
    word_d  = word_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    flag_d  = flag_hit;
    adet_d  = abort_hit;
    idle_d  = idle_hit;
    asig_d  = 1'b0;
    eof_d   = 1'b0;
    err_d   = 1'b0;
    wr_d    = 1'b0;
    if (Rx) ones_d = idle_hit ? ones_q : ones_q + 1'b1;
    if (flag_hit) begin
      // Flag bits never reach the assembler.
      mask_d  = {7'b0, ~stuffed};
      state_d = SYNC;
      if (state_q == FRAME) begin
        if ((bit_q == '0) && (wcnt_q >= W_MIN)) eof_d = 1'b1;
        else                                   err_d = 1'b1;
      end
    end else if (abort_hit || idle_hit) begin
      state_d = IDLE;
      if (abort_hit) begin
        mask_d = {7'b0, ~stuffed};
        ovf_d  = 1'b0;
        if (state_q == FRAME) asig_d = 1'b1;
      end
    end else if (mask_q[7] && (state_q != IDLE)) begin
      if (state_q == SYNC) begin
        state_d = FRAME;
        ovf_d   = 1'b0;
      end
      word_d = {sr_q[7], word_q[DATA_W-1:1]};
      bit_d  = bcur + 1'b1;
      wcnt_d = wcur;
      if (bcur == B_LAST) begin
        bit_d = '0;
        if (wcur != W_OVF) wcnt_d = wcur + 1'b1;
        if (wcur < W_MAX) begin
          data_d = word_d;
          wr_d   = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      mask_q  <= '0;
      ones_q  <= '0;
      bit_q   <= '0;
      wcnt_q  <= '0;
      word_q  <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      adet_q  <= 1'b0;
      asig_q  <= 1'b0;
      idle_q  <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      mask_q  <= mask_d;
      ones_q  <= ones_d;
      bit_q   <= bit_d;
      wcnt_q  <= wcnt_d;
      word_q  <= word_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      adet_q  <= adet_d;
      asig_q  <= asig_d;
      idle_q  <= idle_d;
      eof_q   <= eof_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Rx_FlagDetect  = flag_q;
  assign Rx_AbortDetect = adet_q;
  assign Rx_AbortSignal = asig_q;
  assign Rx_IdleDetect  = idle_q;
  assign Rx_ValidFrame  = (state_q == FRAME);
  assign Rx_Data        = data_q;
  assign Rx_WrBuff      = wr_q;
  assign Rx_EoF         = eof_q;
  assign Rx_FrameError  = err_q;
  assign Rx_Overflow    = ovf_q;

  hdlc_sat_counter #(.CNT_W(CNT_W)) u_flag_cnt (
    .clk_i (Clk),
    .rst_i (Rst),
    .inc_i (flag_q),
    .clr_i (Cnt_Clear),
    .cnt_o (Rx_FlagCnt)
  );

  hdlc_sat_counter #(.CNT_W(CNT_W)) u_abort_cnt (
    .clk_i (Clk),
    .rst_i (Rst),
    .inc_i (asig_q),
    .clr_i (Cnt_Clear),
    .cnt_o (Rx_AbortCnt)
  );

  hdlc_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk_i (Clk),
    .rst_i (Rst),
    .inc_i (err_q),
    .clr_i (Cnt_Clear),
    .cnt_o (Rx_ErrCnt)
  );

endmodule
